// File: rtl/accu_pkg.sv
// Shared types for the multi-channel modular accumulator.
package accu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Widest accumulator the result struct can carry; the ALU zero-extends into it.
    localparam int RES_W = 32;

    typedef struct packed {
        logic [RES_W-1:0] acc;
        logic             wrap;
    } res_t;

endpackage

// File: rtl/accu_mc_alu.sv
// Combinational next-value unit: (acc, d, op) -> {next, wrap}.
module accu_alu
    import accu_pkg::*;
#(
    parameter int              DW   = 16,
    parameter longint unsigned M    = 1000,
    parameter mode_e           MODE = MODE_WRAP
) (
    input  logic [DW-1:0] acc_i,
    input  logic [DW-1:0] d_i,
    input  op_e           op_i,
    output res_t          res_o
);

    // DW+1 bits hold both M (up to 2**DW) and the raw sum of two DW-bit values.
    localparam logic [DW:0] MV   = M[DW:0];
    localparam logic [DW:0] MMAX = MV - {{DW{1'b0}}, 1'b1};

    logic [DW:0] a_w;
    logic [DW:0] b_w;
    logic [DW:0] s_w;
    logic        wrap_w;

    // Compute the wrapped or clamped next accumulator value for the selected op.
    always_comb begin
        a_w    = {1'b0, acc_i};
        b_w    = {1'b0, d_i};
        s_w    = '0;
        wrap_w = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                s_w = a_w + b_w;
                if (MODE == MODE_WRAP) begin
                    if (s_w >= MV) begin
                        s_w    = s_w - MV;
                        wrap_w = 1'b1;
                    end
                end else if (s_w > MMAX) begin
                    s_w    = MMAX;
                    wrap_w = 1'b1;
                end
            end
            OP_SUB: begin
                if (a_w < b_w) begin
                    wrap_w = 1'b1;
                    s_w    = (MODE == MODE_WRAP) ? (a_w + MV - b_w) : '0;
                end else begin
                    s_w = a_w - b_w;
                end
            end
            OP_LOAD: s_w = b_w;
            OP_CLR:  s_w = '0;
            default: s_w = '0;
        endcase
        // Truncation to DW keeps out-of-contract operands from growing the state.
        res_o              = '0;
        res_o.acc[DW-1:0]  = s_w[DW-1:0];
        res_o.wrap         = wrap_w;
    end

endmodule

// File: rtl/accu_mc.sv
// Multi-channel modular accumulator with a registered valid/ready result stream.
module accu_mc
    import accu_pkg::*;
#(
    parameter int              DW   = 16,
    parameter int              CH   = 4,
    parameter longint unsigned M    = 1000,
    parameter mode_e           MODE = MODE_WRAP,
    localparam int             CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  op_e            in_op,
    input  logic [DW-1:0]  in_d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [DW-1:0]  out_acc,
    output logic           out_wrap
);

    logic [DW-1:0]  acc_q [CH];
    logic [DW-1:0]  acc_d [CH];
    logic           out_valid_q;
    logic [CHW-1:0] out_ch_q;
    logic [DW-1:0]  out_acc_q;
    logic           out_wrap_q;

    logic           accept;
    logic [DW-1:0]  cur;
    res_t           res;

    // No skid buffer: a new command is taken only when the output slot frees this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Select the operand; a simultaneous clear makes the target channel read as zero.
    always_comb begin
        cur = '0;
        if (!clr && (int'(in_ch) < CH)) begin
            cur = acc_q[in_ch];
        end
    end

    accu_alu #(
        .DW   (DW),
        .M    (M),
        .MODE (MODE)
    ) u_alu (
        .acc_i (cur),
        .d_i   (in_d),
        .op_i  (in_op),
        .res_o (res)
    );

    // Next channel state: clear everything, but an accepted result wins for its channel.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            acc_d[i] = clr ? '0 : acc_q[i];
            if (accept && (int'(in_ch) == i)) begin
                acc_d[i] = res.acc[DW-1:0];
            end
        end
    end

    // Channel register array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Output register: load on accept, drop valid after a handshake with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_acc_q   <= '0;
            out_wrap_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= in_ch;
            out_acc_q   <= res.acc[DW-1:0];
            out_wrap_q  <= res.wrap;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_acc   = out_acc_q;
    assign out_wrap  = out_wrap_q;

endmodule

// File: tb/tb_accu_mc.sv
// Self-checking bench: a WRAP and a SAT instance against a queue-based reference model.
module tb_accu_mc;
    import accu_pkg::*;

    localparam int MOD = 1000;

    typedef struct {
        int ch;
        int acc;
        bit wrap;
    } exp_t;

    logic clk;
    logic rst;
    logic clr;

    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][1:0]  in_ch;
    op_e              in_op [2];
    logic [1:0][15:0] in_d;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][1:0]  out_ch;
    logic [1:0][15:0] out_acc;
    logic [1:0]       out_wrap;

    int   model [2][4];
    exp_t expq  [2][$];
    int   last_acc [2];
    int   last_ch  [2];
    bit   last_wrap[2];
    int   pops     [2];
    int   checks;
    int   errors;

    accu_mc #(.DW(16), .CH(4), .M(MOD), .MODE(MODE_WRAP)) dut_w (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ch(in_ch[0]),
        .in_op(in_op[0]), .in_d(in_d[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ch(out_ch[0]),
        .out_acc(out_acc[0]), .out_wrap(out_wrap[0])
    );

    accu_mc #(.DW(16), .CH(4), .M(MOD), .MODE(MODE_SAT)) dut_s (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ch(in_ch[1]),
        .in_op(in_op[1]), .in_d(in_d[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ch(out_ch[1]),
        .out_acc(out_acc[1]), .out_wrap(out_wrap[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic written from the modular / clamping rules.
    function automatic void ref_next(input bit sat, input int a, input op_e op, input int d,
                                     output int n, output bit w);
        n = 0;
        w = 1'b0;
        case (op)
            OP_ADD: begin
                if (!sat) begin
                    n = (a + d) % MOD;
                    w = (a + d) >= MOD;
                end else begin
                    w = (a + d) > MOD - 1;
                    n = w ? MOD - 1 : a + d;
                end
            end
            OP_SUB: begin
                w = a < d;
                if (!sat) n = (a - d + MOD) % MOD;
                else      n = w ? 0 : a - d;
            end
            OP_LOAD: n = d;
            default: n = 0;
        endcase
    endfunction

    task automatic flush_model();
        for (int k = 0; k < 2; k++) begin
            expq[k].delete();
            for (int c = 0; c < 4; c++) model[k][c] = 0;
        end
    endtask

    // One clock cycle: drive unit u (the other idles and drains), check both outputs, advance.
    task automatic step(input int u, input bit v, input int ch, input op_e op, input int d,
                        input bit ordy, input bit c);
        int  sz [2];
        bit  acc_exp;
        int  base;
        int  n;
        bit  w;
        exp_t e;
        in_valid[u]    = v;
        in_ch[u]       = ch[1:0];
        in_op[u]       = op;
        in_d[u]        = d[15:0];
        out_ready[u]   = ordy;
        in_valid[1-u]  = 1'b0;
        out_ready[1-u] = 1'b1;
        clr            = c;
        #1;
        for (int k = 0; k < 2; k++) begin
            sz[k] = expq[k].size();
            check($sformatf("u%0d_out_valid", k), 32'(out_valid[k]), 32'(sz[k] > 0));
            check($sformatf("u%0d_in_ready", k), 32'(in_ready[k]), 32'((sz[k] == 0) || out_ready[k]));
            if (sz[k] > 0) begin
                e = expq[k][0];
                check($sformatf("u%0d_out_ch", k), 32'(out_ch[k]), 32'(e.ch));
                check($sformatf("u%0d_out_acc", k), 32'(out_acc[k]), 32'(e.acc));
                check($sformatf("u%0d_out_wrap", k), 32'(out_wrap[k]), 32'(e.wrap));
                if (out_ready[k]) begin
                    last_acc[k]  = int'(out_acc[k]);
                    last_ch[k]   = int'(out_ch[k]);
                    last_wrap[k] = out_wrap[k];
                    pops[k]++;
                    void'(expq[k].pop_front());
                end
            end
        end
        acc_exp = v && ((sz[u] == 0) || ordy);
        base    = c ? 0 : model[u][ch];
        ref_next(u == 1, base, op, d, n, w);
        if (c) begin
            for (int k = 0; k < 2; k++)
                for (int q = 0; q < 4; q++) model[k][q] = 0;
        end
        if (acc_exp) begin
            model[u][ch] = n;
            e.ch = ch; e.acc = n; e.wrap = w;
            expq[u].push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic cmd(input int u, input int ch, input op_e op, input int d);
        step(u, 1'b1, ch, op, d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int u);
        step(u, 1'b0, 0, OP_ADD, 0, 1'b1, 1'b0);
    endtask

    task automatic expect_last(input string tag, input int u, input int acc, input bit wrap);
        check({tag, "_acc"}, 32'(last_acc[u]), 32'(acc));
        check({tag, "_wrap"}, 32'(last_wrap[u]), 32'(wrap));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        clr = 1'b0;
        checks = 0;
        errors = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_ch[k] = '0; in_op[k] = OP_ADD; in_d[k] = '0;
            out_ready[k] = 1'b1; pops[k] = 0; last_acc[k] = -1; last_ch[k] = -1; last_wrap[k] = 1'b0;
        end
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_u%0d_out_valid", k), 32'(out_valid[k]), 32'(0));
            check($sformatf("rst_u%0d_out_acc", k), 32'(out_acc[k]), 32'(0));
            check($sformatf("rst_u%0d_out_ch", k), 32'(out_ch[k]), 32'(0));
            check($sformatf("rst_u%0d_out_wrap", k), 32'(out_wrap[k]), 32'(0));
            check($sformatf("rst_u%0d_in_ready", k), 32'(in_ready[k]), 32'(1));
        end
        @(negedge clk);

        // WRAP: 300 accumulated four times on ch0
        for (int i = 0; i < 3; i++) begin
            cmd(0, 0, OP_ADD, 300);
            idle(0);
            expect_last($sformatf("add300_%0d", i), 0, 300 * (i + 1), 1'b0);
        end
        cmd(0, 0, OP_ADD, 300);
        idle(0);
        expect_last("add300_wrap", 0, 200, 1'b1);

        // Interleaved back-to-back channels
        pops[0] = 0;
        for (int i = 0; i < 4; i++) begin
            cmd(0, 1, OP_ADD, 7);
            cmd(0, 2, OP_ADD, 5);
        end
        idle(0);
        check("interleave_pops", 32'(pops[0]), 32'(8));
        check("interleave_last_ch", 32'(last_ch[0]), 32'(2));
        expect_last("interleave_ch2", 0, 20, 1'b0);
        cmd(0, 1, OP_ADD, 0);
        idle(0);
        expect_last("interleave_ch1", 0, 28, 1'b0);

        // SAT instance
        cmd(1, 3, OP_LOAD, 990); idle(1); expect_last("sat_load", 1, 990, 1'b0);
        cmd(1, 3, OP_ADD, 15);   idle(1); expect_last("sat_add", 1, 999, 1'b1);
        cmd(1, 3, OP_SUB, 999);  idle(1); expect_last("sat_sub999", 1, 0, 1'b0);
        cmd(1, 3, OP_SUB, 1);    idle(1); expect_last("sat_sub1", 1, 0, 1'b1);

        // Backpressure: held result, stalled commands, release
        cmd(0, 0, OP_LOAD, 123);
        pops[0] = 0;
        for (int i = 0; i < 5; i++) step(0, 1'b1, 0, OP_ADD, 1, 1'b0, 1'b0);
        check("bp_no_pop", 32'(pops[0]), 32'(0));
        step(0, 1'b1, 0, OP_ADD, 1, 1'b1, 1'b0);
        check("bp_release_pop", 32'(pops[0]), 32'(1));
        expect_last("bp_held", 0, 123, 1'b0);
        idle(0);
        expect_last("bp_after", 0, 124, 1'b0);

        // clr with a simultaneous accepted ADD
        cmd(0, 0, OP_LOAD, 700);
        cmd(0, 1, OP_LOAD, 400);
        step(0, 1'b1, 0, OP_ADD, 50, 1'b1, 1'b1);
        idle(0);
        expect_last("clr_add", 0, 50, 1'b0);
        cmd(0, 0, OP_ADD, 0); idle(0); expect_last("clr_ch0", 0, 50, 1'b0);
        cmd(0, 1, OP_ADD, 0); idle(0); expect_last("clr_ch1", 0, 0, 1'b0);

        // Asynchronous reset mid-burst
        cmd(0, 2, OP_ADD, 9);
        cmd(0, 3, OP_ADD, 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid[0]), 32'(0));
        check("arst_out_acc", 32'(out_acc[0]), 32'(0));
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        cmd(0, 2, OP_ADD, 1);
        idle(0);
        expect_last("arst_after", 0, 1, 1'b0);

        // Randomized traffic on both instances
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 400; i++) begin
                step(u, ($urandom % 4) != 0, int'($urandom % 4), op_e'($urandom % 4),
                     int'($urandom % MOD), ($urandom % 4) != 0, ($urandom % 32) == 0);
            end
            idle(u);
            idle(u);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accu_mc.md
# accu_mc

Multi-channel modular accumulator: a CH-channel generalisation of the single-register accumulators, holding one DW-bit accumulator per channel in flops. It updates the selected channel per accepted transaction with add, subtract, load or clear, in wrap-modulo-M or saturating mode. Each result is returned on a registered valid/ready output stream together with a wrap/saturate flag. It sits between a channel-interleaved command source (e.g. NCO phase steps, per-channel event counters) and downstream consumers.

## Interface
Parameters:
- DW, 16, accumulator and data width
- CH, 4, number of channels; CHW = max(1, $clog2(CH))
- M, 1000, modulus; legal range 2 <= M <= 2**DW
- MODE, MODE_WRAP, MODE_WRAP (modulo M) or MODE_SAT (clamp to [0, M-1])

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of all channels
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_ch  in  CHW  target channel (< CH)
- in_op  in  2  op_e: OP_ADD, OP_SUB, OP_LOAD, OP_CLR
- in_d  in  DW  operand; contract: in_d < M
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_ch  out  CHW  channel of result
- out_acc  out  DW  new accumulator value
- out_wrap  out  1  wrap (MODE_WRAP) or clamp (MODE_SAT) occurred

## Operation
- Accepted command: acc[in_ch] <= next on the same edge; the result is loaded into the output register.
- Arithmetic is done at DW+1 bits; stored values are always < M.
- OP_ADD: s = acc + d.
  - WRAP: s >= M gives s - M, wrap=1.
  - SAT: s > M-1 gives M-1, wrap=1.
- OP_SUB:
  - WRAP: acc < d gives acc - d + M, wrap=1.
  - SAT: acc < d gives 0, wrap=1.
- OP_LOAD: next = d, wrap=0. OP_CLR: next = 0, wrap=0.
- clr: all acc[] <= 0 at the edge.
  - If a command is accepted in the same cycle, it is computed with acc[in_ch] treated as 0.
  - Its result is written to acc[in_ch], overriding the clear for that channel only, and is still emitted.
- in_d >= M or in_ch >= CH is out of contract. The design only guarantees that stored values stay < 2**DW.

## Timing
- Reset values: acc[] = 0, out_valid = 0, out_ch = 0, out_acc = 0, out_wrap = 0, in_ready = 1.
- in_ready = !out_valid || out_ready (combinational); there is no skid buffer.
- Latency: a command accepted at edge t has its result visible with out_valid = 1 after edge t.
- Throughput is 1 command per cycle while out_ready = 1.
- Back-to-back commands to the same channel see the updated value with no bubble, because state is in flops.
- out_* hold stable while out_valid && !out_ready.
- out_valid falls after a handshake with no new accept in the same cycle.
- Reset asserted mid-stream: the pending output and all channel state are discarded immediately.
- clr does not affect out_* of a result already held.

## Structure
- Package accu_pkg holds:
  - op_e (2-bit: OP_ADD=0, OP_SUB=1, OP_LOAD=2, OP_CLR=3)
  - mode_e (MODE_WRAP=0, MODE_SAT=1)
  - a result struct {acc, wrap}
- Sub-module accu_alu: a combinational next-value unit (acc, d, op) -> {next, wrap}, parametrised by DW, M, MODE.
- Top level holds the channel register array, the handshake, and the output register.

## Test plan
All scenarios use CH=4, DW=16, M=1000.
- Reset, then ADD ch0 d=300 three times (MODE_WRAP) -> out_acc 300, 600, 900, wrap=0; a fourth ADD gives 200, wrap=1.
- Interleave ADD ch1 d=7 and ch2 d=5 back-to-back, 4 each, out_ready=1 -> ch1 28 and ch2 20.
  - 8 consecutive out_valid cycles, results in order, channels unaffected by each other.
- MODE_SAT: LOAD ch3 990, then ADD 15 -> 999 wrap=1; then SUB 1000-1=999 -> 0 wrap=0; then SUB 1 -> 0 wrap=1.
- Backpressure: out_ready=0 for 5 cycles with a result held.
  - in_ready=0, out_* stable, no ch0 update.
  - Release -> exactly one handshake, next command accepted that cycle.
- clr with a simultaneous ADD ch0 d=50 while ch0=700 and ch1=400 -> out_acc=50, ch0=50, ch1=0.
- Assert rst asynchronously mid-burst (between edges) -> out_valid drops immediately.
  - After release, ADD ch2 d=1 -> 1.
